// File: rtl/minibus_arbiter.sv
// minibus_arbiter: N-to-1 minibus master arbiter, round-robin, grant held until bus_res.ready.
// Define MINIBUS_ARB_FIXED_PRIO_EN for fixed priority (lowest active index wins).
package minibus_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ren;
    logic        wen;
  } minibus_req_pack;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
  } minibus_res_pack;

endpackage

module minibus_arbiter
  import minibus_pkg::*;
#(
  parameter int unsigned MASTER_COUNT = 2,
  localparam int unsigned GW = $clog2(MASTER_COUNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  minibus_req_pack m_req [MASTER_COUNT],
  output minibus_res_pack m_res [MASTER_COUNT],
  output minibus_req_pack bus_req,
  input  minibus_res_pack bus_res,
  output logic [GW-1:0]   grant_idx,
  output logic            busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           last_grant_next;
  logic [GW-1:0]           grant_next;
  logic [MASTER_COUNT-1:0] active;
  logic [GW-1:0]           winner;
  logic                    found;

  // A master is requesting when either strobe is set.
  always_comb begin : req_active
    active = '0;
    for (int unsigned i = 0; i < MASTER_COUNT; i++) begin
      active[i] = m_req[i].ren | m_req[i].wen;
    end
  end

`ifdef MINIBUS_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest active index is the last writer.
  always_comb begin : pick
    winner = '0;
    found  = 1'b0;
    for (int i = int'(MASTER_COUNT) - 1; i >= 0; i--) begin
      if (active[i]) begin
        winner = GW'(i);
        found  = 1'b1;
      end
    end
  end
`else
  // Round-robin: first active master after last_grant, wrapping modulo MASTER_COUNT.
  always_comb begin : pick
    int unsigned             cand;
    logic [MASTER_COUNT-1:0] rot;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    rot    = '0;
    for (int unsigned off = 1; off <= MASTER_COUNT; off++) begin
      cand = (32'(last_grant) + off) % MASTER_COUNT;
      rot  = active >> cand;
      if (!found && rot[0]) begin
        winner = GW'(cand);
        found  = 1'b1;
      end
    end
  end
`endif

  always_comb begin : fsm_next
    state_next      = state;
    grant_next      = grant_idx;
    last_grant_next = last_grant;
    bus_req         = '0;
    for (int unsigned i = 0; i < MASTER_COUNT; i++) begin
      m_res[i] = '0;
    end
    case (state)
      IDLE: begin
        if (found) begin
          state_next      = BUSY;
          grant_next      = winner;
          last_grant_next = winner;
        end
      end
      BUSY: begin
        // Owner is routed straight through; everyone else sees ready=0.
        for (int unsigned i = 0; i < MASTER_COUNT; i++) begin
          if (GW'(i) == grant_idx) begin
            bus_req  = m_req[i];
            m_res[i] = bus_res;
          end
        end
        if (bus_res.ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : fsm_reg
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(MASTER_COUNT - 1);
      grant_idx  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      grant_idx  <= grant_next;
      busy       <= (state_next == BUSY);
    end
  end

endmodule

// File: tb/tb_minibus_arbiter.sv
// Self-checking bench for minibus_arbiter: directed scenarios plus random traffic vs. a behavioural model.
// Honours MINIBUS_ARB_FIXED_PRIO_EN in both the expected grant orders and the model.
module tb_minibus_arbiter;
  import minibus_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  minibus_req_pack m_req [N];
  minibus_res_pack m_res [N];
  minibus_req_pack bus_req;
  minibus_res_pack bus_res;
  logic [1:0]      grant_idx;
  logic            busy;

  int total = 0;
  int bad   = 0;

  // Model: who owns the bus (if anyone), who won last, what grant_idx shows.
  bit exp_busy;
  int exp_owner;
  int exp_last;
  int exp_gidx;

  minibus_arbiter #(.MASTER_COUNT(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_res    (m_res),
    .bus_req  (bus_req),
    .bus_res  (bus_res),
    .grant_idx(grant_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic minibus_req_pack mk_req(input logic ren, input logic wen);
    minibus_req_pack r;
    r.addr  = $urandom;
    r.wdata = $urandom;
    r.wstrb = 4'($urandom);
    r.ren   = ren;
    r.wen   = wen;
    return r;
  endfunction

  function automatic minibus_res_pack mk_res(input logic ready);
    minibus_res_pack r;
    r.rdata = $urandom;
    r.ready = ready;
    return r;
  endfunction

  // Next owner from the arbitration rule, -1 when nobody asks.
  function automatic int pick(input int last);
`ifdef MINIBUS_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (m_req[i].ren || m_req[i].wen) return i;
`else
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (m_req[c].ren || m_req[c].wen) return c;
    end
`endif
    return -1;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) m_req[i] = '0;
    bus_res = '0;
  endtask

  task automatic model_update();
    int w;
    if (rst) begin
      exp_busy = 1'b0;
      exp_last = N - 1;
      exp_gidx = 0;
    end else if (!exp_busy) begin
      w = pick(exp_last);
      if (w >= 0) begin
        exp_busy  = 1'b1;
        exp_owner = w;
        exp_last  = w;
        exp_gidx  = w;
      end
    end else if (bus_res.ready) begin
      exp_busy = 1'b0;
    end
  endtask

  // Called at a negedge with inputs already driven: check outputs, advance one clock.
  task automatic cycle();
    #1;
    chk("busy", 128'(busy), 128'(exp_busy));
    chk("gidx", 128'(grant_idx), 128'(exp_gidx));
    chk("bus_req", 128'(bus_req), exp_busy ? 128'(m_req[exp_owner]) : 128'(0));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("m_res%0d", i), 128'(m_res[i]),
          (exp_busy && i == exp_owner) ? 128'(bus_res) : 128'(0));
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int grants[$];
    int exp_rr[4];
    exp_owner = 0;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    do_reset();

    // Reset state.
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_gidx", 128'(grant_idx), 128'(0));
    chk("rst_bus_req", 128'(bus_req), 128'(0));

    // Single master 0, completes after a few BUSY cycles.
    m_req[0] = mk_req(1'b1, 1'b0);
    cycle();
    #1;
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_gidx", 128'(grant_idx), 128'(0));
    chk("t1_bus_req", 128'(bus_req), 128'(m_req[0]));
    cycle();
    cycle();
    bus_res = mk_res(1'b1);
    #1;
    chk("t1_ready", 128'(m_res[0].ready), 128'(1));
    cycle();
    clear_inputs();
    chk("t1_done", 128'(busy), 128'(0));
    cycle();

    // All masters request continuously, immediate completion.
    do_reset();
    for (int i = 0; i < N; i++) m_req[i] = mk_req(1'b1, 1'b0);
    bus_res = mk_res(1'b1);
    for (int c = 0; c < 9; c++) begin
      #1;
      if (busy) grants.push_back(int'(grant_idx));
      cycle();
    end
`ifdef MINIBUS_ARB_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 2, 3};
`endif
    chk("t2_ngrants", 128'(grants.size() >= 4), 128'(1));
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk($sformatf("t2_grant%0d", k), 128'(grants[k]), 128'(exp_rr[k]));

    // Master 1 owns the bus, master 0 asks mid-transaction and must stall.
    do_reset();
    m_req[1] = mk_req(1'b0, 1'b1);
    cycle();
    m_req[0] = mk_req(1'b0, 1'b1);
    cycle();
    bus_res = mk_res(1'b1);
    #1;
    chk("t4_stall0", 128'(m_res[0].ready), 128'(0));
    chk("t4_owner1", 128'(m_res[1].ready), 128'(1));
    cycle();
    m_req[1] = '0;
    bus_res = mk_res(1'b0);
    cycle();
    chk("t4_gidx", 128'(grant_idx), 128'(0));
    chk("t4_busy", 128'(busy), 128'(1));

    // Reset in the middle of a transaction that never completes.
    do_reset();
    m_req[2] = mk_req(1'b1, 1'b0);
    cycle();
    cycle();
    rst = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_bus_req", 128'(bus_req), 128'(0));
    rst = 1'b0;
    m_req[0] = mk_req(1'b1, 1'b0);
    cycle();
    chk("t5_first", 128'(grant_idx), 128'(0));

    // Masters 1 and 3 with last_grant = N-1: wrap-around order.
    do_reset();
    m_req[1] = mk_req(1'b1, 1'b0);
    m_req[3] = mk_req(1'b0, 1'b1);
    bus_res = mk_res(1'b1);
    cycle();
    chk("t6_first", 128'(grant_idx), 128'(1));
    cycle();
    cycle();
`ifdef MINIBUS_ARB_FIXED_PRIO_EN
    chk("t6_second", 128'(grant_idx), 128'(1));
`else
    chk("t6_second", 128'(grant_idx), 128'(3));
`endif

    // Random traffic, with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) m_req[i] = mk_req(1'($urandom), 1'($urandom_range(3) == 0));
      end
      bus_res = mk_res($urandom_range(2) == 0);
      rst = ($urandom_range(99) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
